// File: rtl/arf096b192e1r1w0cbbeheaa4acw_rcb_pkg.sv
// Shared types and helpers for the multi-channel regional clock buffer
// power controller.
//   rcb_state_e : per-channel power FSM state
//   cnt_width() : idle/wake counter width, never narrower than 1 bit
package arf096b192e1r1w0cbbeheaa4acw_rcb_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } rcb_state_e;

    // Width needed to hold the larger of the idle and wake windows.
    function automatic int unsigned cnt_width(input int unsigned idle_cyc,
                                              input int unsigned wake_cyc);
        int unsigned mx;
        mx = (idle_cyc > wake_cyc) ? idle_cyc : wake_cyc;
        return (mx == 0) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/arf096b192e1r1w0cbbeheaa4acw_rcb_chan_fsm.sv
// One regional clock channel: OFF/WAKE/ON/DRAIN power FSM with a shared
// wake/idle down-counter, plus an optional saturating gated-cycle counter
// (present only when ARF096B192E1R1W0CBBEHEAA4ACW_RCB_GATE_STATS_EN is defined).
//   clk, rst_n : grid clock, async active-low reset
//   rp_en      : channel power enable request
//   force_en   : override/scan ungate (does not affect the FSM)
//   en_st      : registered FSM enable
//   rdy        : registered clock-ready
//   en_c       : combinational effective enable to the clock cell
//   gate_cnt   : gated-cycle count (macro only)
module arf096b192e1r1w0cbbeheaa4acw_rcb_chan_fsm
    import arf096b192e1r1w0cbbeheaa4acw_rcb_pkg::*;
#(
    parameter int unsigned IDLE_CYC = 8,
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned RST_ON   = 1,
    parameter int unsigned STAT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rp_en,
    input  logic force_en,
    output logic en_st,
    output logic rdy,
    output logic en_c
`ifdef ARF096B192E1R1W0CBBEHEAA4ACW_RCB_GATE_STATS_EN
    ,
    output logic [STAT_W-1:0] gate_cnt
`endif
);

    localparam int unsigned CNT_W     = cnt_width(IDLE_CYC, WAKE_CYC);
    localparam rcb_state_e  RST_STATE = (RST_ON != 0) ? ON : OFF;
    localparam logic        RST_VAL   = (RST_ON != 0) ? 1'b1 : 1'b0;

    rcb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_st_q, en_st_d;
    logic             rdy_q, rdy_d;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                if (rp_en) begin
                    if (WAKE_CYC == 0) begin
                        state_d = ON;
                    end else begin
                        state_d = WAKE;
                        cnt_d   = CNT_W'(WAKE_CYC - 1);
                    end
                end
            end
            // rp_en ignored here so a started wake always completes.
            WAKE: begin
                if (cnt_q == '0) state_d = ON;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ON: begin
                if (!rp_en) begin
                    if (IDLE_CYC == 0) begin
                        state_d = OFF;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(IDLE_CYC - 1);
                    end
                end
            end
            DRAIN: begin
                if (rp_en) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
        en_st_d = (state_d != OFF);
        rdy_d   = (state_d == ON) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            en_st_q <= RST_VAL;
            rdy_q   <= RST_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_st_q <= en_st_d;
            rdy_q   <= rdy_d;
        end
    end

    assign en_st = en_st_q;
    assign rdy   = rdy_q;
    assign en_c  = en_st_q | force_en;

`ifdef ARF096B192E1R1W0CBBEHEAA4ACW_RCB_GATE_STATS_EN
    logic [STAT_W-1:0] gate_cnt_q, gate_cnt_d;

    // Saturating count of cycles with the regional clock gated off.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        if (!en_c && (gate_cnt_q != '1)) gate_cnt_d = gate_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gate_cnt_q <= '0;
        else        gate_cnt_q <= gate_cnt_d;
    end

    assign gate_cnt = gate_cnt_q;
`else
    localparam int unsigned UNUSED_STAT_W = STAT_W;
`endif

endmodule

// File: rtl/rcb_and.sv
// Behavioural stand-in for the regional clock buffer AND cell.
// A low-phase transparent latch holds the enable so the gated clock never
// glitches; fd/rd are local clock-pulse trim bits with no logical effect.
//   ck     : grid clock in
//   en     : clock enable
//   fd, rd : LCP trim bits
//   ckg    : gated clock out
module rcb_and (
    input  logic ck,
    input  logic en,
    input  logic fd,
    input  logic rd,
    output logic ckg
);

    logic en_l;
    logic unused_lcp;

    // Enable captured while the clock is low, held while it is high.
    always_latch begin
        if (!ck) en_l <= en;
    end

    assign unused_lcp = fd ^ rd;
    assign ckg        = ck & en_l;

endmodule

// File: rtl/arf096b192e1r1w0cbbeheaa4acw_gclk_rcb_pwr_ctl_mc.sv
// Multi-channel regional clock buffer with per-channel idle-hysteresis
// power control. Optional gated-cycle statistics are enabled by defining
// ARF096B192E1R1W0CBBEHEAA4ACW_RCB_GATE_STATS_EN.
//   CkGridX1N      : grid clock (never gated)
//   RstbX1N        : async active-low reset
//   RPEn           : per-channel power enable
//   RPOvrd         : global override, forces all clocks on
//   FscanClkUngate : scan ungate, forces all clocks on
//   Fd, Rd         : per-channel LCP bits to the clock cell
//   CkRcbX1N       : gated regional clocks
//   RcbEnSt        : registered FSM enable (excludes overrides)
//   RcbRdy         : channel clock settled and running
//   GateCnt        : packed gated-cycle counters (macro only)
module arf096b192e1r1w0cbbeheaa4acw_gclk_rcb_pwr_ctl_mc
    import arf096b192e1r1w0cbbeheaa4acw_rcb_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned IDLE_CYC = 8,
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned RST_ON   = 1,
    parameter int unsigned STAT_W   = 16
) (
    input  logic           CkGridX1N,
    input  logic           RstbX1N,
    input  logic [NCH-1:0] RPEn,
    input  logic           RPOvrd,
    input  logic           FscanClkUngate,
    input  logic [NCH-1:0] Fd,
    input  logic [NCH-1:0] Rd,
    output logic [NCH-1:0] CkRcbX1N,
    output logic [NCH-1:0] RcbEnSt,
    output logic [NCH-1:0] RcbRdy
`ifdef ARF096B192E1R1W0CBBEHEAA4ACW_RCB_GATE_STATS_EN
    ,
    output logic [NCH*STAT_W-1:0] GateCnt
`endif
);

    logic           force_en_c;
    logic [NCH-1:0] en_c;

    assign force_en_c = RPOvrd | FscanClkUngate;

    // One FSM plus clock cell per regional channel.
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        arf096b192e1r1w0cbbeheaa4acw_rcb_chan_fsm #(
            .IDLE_CYC (IDLE_CYC),
            .WAKE_CYC (WAKE_CYC),
            .RST_ON   (RST_ON),
            .STAT_W   (STAT_W)
        ) u_fsm (
            .clk      (CkGridX1N),
            .rst_n    (RstbX1N),
            .rp_en    (RPEn[g]),
            .force_en (force_en_c),
            .en_st    (RcbEnSt[g]),
            .rdy      (RcbRdy[g]),
            .en_c     (en_c[g])
`ifdef ARF096B192E1R1W0CBBEHEAA4ACW_RCB_GATE_STATS_EN
            ,
            .gate_cnt (GateCnt[g*STAT_W +: STAT_W])
`endif
        );

        rcb_and u_rcb_and (
            .ck  (CkGridX1N),
            .en  (en_c[g]),
            .fd  (Fd[g]),
            .rd  (Rd[g]),
            .ckg (CkRcbX1N[g])
        );
    end

endmodule

// File: doc/arf096b192e1r1w0cbbeheaa4acw_gclk_rcb_pwr_ctl_mc.md
# arf096b192e1r1w0cbbeheaa4acw_gclk_rcb_pwr_ctl_mc

Multi-channel regional clock buffer with per-channel idle-hysteresis power control. It produces NCH gated regional clocks from one grid clock. Each channel runs a small state machine that delays clock shutdown by a programmable idle window and reports clock-ready after a wake settle window. It sits between the grid clock distribution and the array's regional logic, and replaces per-region single-enable RCB instances.

## Interface
- NCH, 4, number of regional clock channels (1..16)
- IDLE_CYC, 8, consecutive idle cycles before a channel gates off (0 = gate immediately)
- WAKE_CYC, 2, settle cycles between enable assertion and RcbRdy (0 = ready immediately)
- RST_ON, 1, reset state of every channel: 1 = ON (clock running), 0 = OFF
- STAT_W, 16, width of the gated-cycle counters (used only with the macro)

Ports:
- CkGridX1N  in  1  grid clock, single clock domain
- RstbX1N  in  1  asynchronous active-low reset
- RPEn  in  NCH  per-channel regional power enable (1 = functional)
- RPOvrd  in  1  global override, forces all channels enabled
- FscanClkUngate  in  1  scan ungate, forces all channels enabled
- Fd  in  NCH  per-channel LCP bit
- Rd  in  NCH  per-channel LCP bit
- CkRcbX1N  out  NCH  gated regional clocks
- RcbEnSt  out  NCH  registered FSM enable (excludes overrides)
- RcbRdy  out  NCH  channel clock settled and running
- GateCnt  out  NCH*STAT_W  gated-cycle counters (macro only)

## Operation
- Per-channel FSM states: OFF, WAKE, ON, DRAIN. The state is encoded in the package enum.
- OFF: RcbEnSt=0, RcbRdy=0. If RPEn=1, go to WAKE and load the wake counter with WAKE_CYC-1. If WAKE_CYC=0, go directly to ON.
- WAKE: RcbEnSt=1, RcbRdy=0. The counter decrements each cycle; at 0 the channel goes to ON. RPEn is ignored in WAKE, so a wake always completes.
- ON: RcbEnSt=1, RcbRdy=1. If RPEn=0, go to DRAIN and load the idle counter with IDLE_CYC-1. If IDLE_CYC=0, go directly to OFF.
- DRAIN: RcbEnSt=1, RcbRdy=1. If RPEn=1, return to ON and discard the counter. Otherwise decrement; at 0 with RPEn=0, go to OFF.
- Effective enable: en[i] = RcbEnSt[i] | RPOvrd | FscanClkUngate.
- en[i], Fd[i] and Rd[i] feed one rcb_and cell per channel. The glitch-free latch is inside the cell, not in this block.
- Overrides do not change FSM state or RcbRdy. Counters run from CkGridX1N, which is never gated.
- Counter width: $clog2(max(IDLE_CYC,WAKE_CYC)+1), with a minimum of 1.
- Channels are fully independent. Simultaneous transitions on all channels are legal.

## Timing
- RPEn is sampled on the rising CkGridX1N edge. RcbEnSt rises 1 cycle after RPEn rises in OFF.
- RcbRdy rises WAKE_CYC+1 cycles after RPEn rises in OFF.
- After RPEn falls in ON, RcbEnSt falls IDLE_CYC+1 cycles later, provided RPEn stays low throughout.
- A 1-cycle RPEn pulse in DRAIN restarts the full idle window.
- Reset (async assert, synchronous deassert handled upstream):
  - RST_ON=1: state ON, RcbEnSt=1, RcbRdy=1.
  - RST_ON=0: state OFF, both outputs 0.
  - Counters reset to 0 in both cases.
- Reset asserted mid-WAKE or mid-DRAIN aborts immediately to the reset state.
- Override-to-clock path is combinational through the cell latch. There is no registered delay.

## Configuration
- Macro: ARF096B192E1R1W0CBBEHEAA4ACW_RCB_GATE_STATS_EN.
- Defined: GateCnt[i] increments on each cycle where en[i]=0. It saturates at all-ones, does not wrap, and resets to 0.
- Not defined: the GateCnt port and counters are absent, and the STAT_W parameter is ignored.

## Structure
- Package arf096b192e1r1w0cbbeheaa4acw_rcb_pkg holds:
  - rcb_state_e enum {OFF, WAKE, ON, DRAIN}.
  - A function for counter width.
- Sub-module arf096b192e1r1w0cbbeheaa4acw_rcb_chan_fsm holds one channel's FSM, counter and optional stat counter. The top instantiates it NCH times in a generate loop, alongside the existing rcb_and cell.

## Test plan
- Default params, RST_ON=1: release reset -> RcbEnSt=4'hF and RcbRdy=4'hF. Drop RPEn[0] -> RcbEnSt[0] falls exactly 9 cycles later, other channels unchanged.
- RPEn[1] 1->0, then a 1-cycle high pulse at idle count 3, then low again -> channel 1 returns to ON and gates 9 cycles after the final fall.
- RST_ON=0, WAKE_CYC=2: raise RPEn[2] -> RcbEnSt[2] at +1 cycle, RcbRdy[2] at +3 cycles. Drop RPEn[2] during WAKE -> channel still reaches ON, then DRAIN.
- All channels OFF, assert FscanClkUngate -> all CkRcbX1N toggle, RcbRdy stays 0, state stays OFF. Same check with RPOvrd.
- IDLE_CYC=0, WAKE_CYC=0: RPEn toggling every cycle -> RcbEnSt follows RPEn with 1-cycle latency. Assert RstbX1N mid-sequence -> outputs immediately take the RST_ON values.
- Macro defined, STAT_W=4, channel held OFF for 20 cycles -> GateCnt saturates at 4'hF. An override cycle does not increment it.
